// File: rtl/kmac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kmac_pkg : shared KMAC/Keccak padding types, suffixes and states    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package kmac_pkg;

  typedef enum logic [1:0] {
    MODE_SHA3   = 2'd0,
    MODE_SHAKE  = 2'd1,
    MODE_CSHAKE = 2'd2,
    MODE_KECCAK = 2'd3
  } mode_e;

  localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;
  localparam logic [7:0] SUFFIX_CSHAKE = 8'h04;
  localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
  localparam logic [7:0] PAD_FINAL     = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_PAD    = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  function automatic logic [7:0] mode_to_suffix(input mode_e m);
    logic [7:0] s;
    case (m)
      MODE_SHA3:   s = SUFFIX_SHA3;
      MODE_SHAKE:  s = SUFFIX_SHAKE;
      MODE_CSHAKE: s = SUFFIX_CSHAKE;
      default:     s = SUFFIX_KECCAK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pad10_1_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pad10_1_stream : byte-stream pad10*1 padder packing rate-sized     |
// | blocks for the Keccak absorb stage.            Revision : 1.0       |
// +--------------------------------------------------------------------+
module pad10_1_stream
  import kmac_pkg::*;
#(
  parameter int RATE_MAX = 168,
  parameter int RATE_W   = $clog2(RATE_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [RATE_W-1:0]     rate_bytes,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*RATE_MAX-1:0] out_block,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  state_e              r_state, w_state_nxt;
  logic [RATE_W-1:0]   r_rate, r_idx;
  logic [7:0]          r_suffix;
  logic                r_pad_pend, r_out_last, r_done, r_err;
  logic [8*RATE_MAX-1:0] w_block;

  logic w_rate_ok, w_start_ok, w_in_hs, w_data_beat, w_last_byte;
  logic w_blk_full, w_out_hs, w_clr, w_pad;

  assign w_rate_ok   = (rate_bytes[2:0] == 3'd0) && (rate_bytes >= RATE_W'(8)) &&
                       (rate_bytes <= RATE_W'(RATE_MAX));
  assign w_start_ok  = (r_state == ST_IDLE) && start && w_rate_ok;
  assign w_in_hs     = in_valid && (r_state == ST_ABSORB);
  assign w_data_beat = w_in_hs && (in_keep || !in_last);
  assign w_last_byte = (r_idx == r_rate - RATE_W'(1));
  assign w_blk_full  = w_data_beat && w_last_byte;
  assign w_out_hs    = (r_state == ST_EMIT) && out_ready;
  assign w_clr       = w_start_ok || w_out_hs;
  assign w_pad       = (r_state == ST_PAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_state_nxt = ST_ABSORB;
      ST_ABSORB: begin
        if (w_blk_full)               w_state_nxt = ST_EMIT;
        else if (w_in_hs && in_last)  w_state_nxt = ST_PAD;
      end
      ST_PAD:    w_state_nxt = ST_EMIT;
      default: begin
        if (out_ready) begin
          if (r_out_last)      w_state_nxt = ST_IDLE;
          else if (r_pad_pend) w_state_nxt = ST_PAD;
          else                 w_state_nxt = ST_ABSORB;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate     <= '0;
      r_suffix   <= '0;
      r_idx      <= '0;
      r_pad_pend <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_out_hs && r_out_last;
      r_err  <= (r_state == ST_IDLE) && start && !w_rate_ok;
      if (w_start_ok) begin
        r_rate   <= rate_bytes;
        r_suffix <= mode_to_suffix(mode_e'(mode));
      end
      if (w_clr)            r_idx <= '0;
      else if (w_data_beat) r_idx <= r_idx + RATE_W'(1);
      // A last byte that fills the block owes a padding-only block afterwards
      if (w_start_ok || w_out_hs)  r_pad_pend <= 1'b0;
      else if (w_blk_full && in_last) r_pad_pend <= 1'b1;
      if (w_pad)         r_out_last <= 1'b1;
      else if (w_out_hs) r_out_last <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < RATE_MAX; gi++) begin : g_byte
    localparam logic [RATE_W-1:0] c_idx = RATE_W'(gi);
    logic [7:0] r_byte;
    logic [7:0] w_pad_val;
    logic       w_we;

    assign w_we      = w_data_beat && (r_idx == c_idx);
    // Suffix and final bit may land on the same byte (e.g. 0x06|0x80)
    assign w_pad_val = ((r_idx == c_idx) ? r_suffix : 8'h00) |
                       ((r_rate - RATE_W'(1) == c_idx) ? PAD_FINAL : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_byte <= '0;
      else if (w_clr)  r_byte <= '0;
      else if (w_we)   r_byte <= in_data;
      else if (w_pad)  r_byte <= r_byte | w_pad_val;
    end

    assign w_block[8*gi +: 8] = r_byte;
  end

  assign in_ready  = (r_state == ST_ABSORB);
  assign out_valid = (r_state == ST_EMIT);
  assign out_block = w_block;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pad10_1_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pad10_1_stream : directed self-checking bench for the padder    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pad10_1_stream;
  localparam int RATE_MAX = 168;
  localparam int RATE_W   = $clog2(RATE_MAX + 1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [RATE_W-1:0]     rate_bytes;
  logic [1:0]            mode;
  logic                  in_valid, in_ready, in_keep, in_last;
  logic [7:0]            in_data;
  logic                  out_valid, out_ready, out_last, done, err;
  logic [8*RATE_MAX-1:0] out_block;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pad10_1_stream #(.RATE_MAX(RATE_MAX), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rate_bytes(rate_bytes), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .out_last(out_last), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned          msg_q[$];
  logic [8*RATE_MAX-1:0] rx_blk[$];
  logic                  rx_last[$];
  int                    last_acc_cyc;
  int                    first_valid_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_msg(input int n);
    int   i = 0;
    int   guard = 0;
    int   beats;
    logic acc;
    beats = (n == 0) ? 1 : n;
    if (n == 0) begin
      in_valid = 1'b1; in_keep = 1'b0; in_last = 1'b1; in_data = 8'h00;
    end
    while (i < beats && guard < 5000) begin
      if (n > 0) begin
        in_valid = 1'b1; in_keep = 1'b1; in_data = msg_q[i]; in_last = (i == n - 1);
      end
      acc = in_ready;
      @(negedge clk); guard++;
      if (acc) begin
        i++;
        if (i == beats) last_acc_cyc = cyc;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0;
    if (guard >= 5000) check("tx_timeout", 0, 1);
  endtask

  task automatic recv_msg(input int stall, input int nb, input bit pad_only);
    int   guard = 0;
    bit   got_last = 0;
    logic lst;
    int   vcyc;
    logic [8*RATE_MAX-1:0] blk0;
    while (!got_last && guard < 5000) begin
      if (out_valid) begin
        blk0 = out_block; lst = out_last; vcyc = cyc;
        for (int s = 0; s < stall; s++) begin
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_block_stable", out_block == blk0, 1);
          check("stall_last_stable", out_last, lst);
          @(negedge clk); guard++;
        end
        out_ready = 1'b1;
        @(negedge clk); guard++;
        out_ready = 1'b0;
        rx_blk.push_back(blk0);
        rx_last.push_back(lst);
        if (lst) begin
          got_last = 1;
          first_valid_cyc = vcyc;
          check("done_pulse", done, 1);
          check("idle_in_ready", in_ready, 0);
          check("idle_out_valid", out_valid, 0);
          @(negedge clk);
          check("done_cleared", done, 0);
        end else if (!(pad_only && rx_blk.size() == nb - 1)) begin
          check("resume_in_ready", in_ready, 1);
        end
      end else begin
        @(negedge clk); guard++;
      end
    end
    if (!got_last) check("rx_timeout", 0, 1);
  endtask

  task automatic run_msg(input int rate, input logic [1:0] m, input logic [7:0] sfx,
                         input int n, input int stall);
    int   nb;
    int   pos;
    logic [7:0] e;
    logic [8*RATE_MAX-1:0] blk;
    nb = n / rate + 1;
    rx_blk.delete(); rx_last.delete();
    start = 1'b1; rate_bytes = RATE_W'(rate); mode = m;
    @(negedge clk);
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    fork
      send_msg(n);
      recv_msg(stall, nb, (n > 0) && (n % rate == 0));
    join
    check("blk_count", rx_blk.size(), nb);
    if ((n % rate != 0) || (n == 0))
      check("pad_latency", first_valid_cyc - last_acc_cyc, 1);
    for (int b = 0; b < nb && b < rx_blk.size(); b++) begin
      blk = rx_blk[b];
      check($sformatf("last_b%0d", b), rx_last[b], (b == nb - 1));
      for (int j = 0; j < RATE_MAX; j++) begin
        pos = b * rate + j;
        e = 8'h00;
        if (j < rate) begin
          if (pos < n) e = msg_q[pos];
          if (b == nb - 1) begin
            if (j == n % rate) e = e | sfx;
            if (j == rate - 1) e = e | 8'h80;
          end
        end
        check($sformatf("blk%0d_byte%0d", b, j), blk[8*j +: 8], e);
      end
    end
  endtask

  task automatic bad_start(input int rate);
    start = 1'b1; rate_bytes = RATE_W'(rate); mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("err_pulse_r%0d", rate), err, 1);
    check($sformatf("err_idle_r%0d", rate), in_ready, 0);
    @(negedge clk);
    check($sformatf("err_clear_r%0d", rate), err, 0);
    check($sformatf("err_still_idle_r%0d", rate), in_ready, 0);
  endtask

  logic [8*RATE_MAX-1:0] tmp;

  initial begin
    rst_n = 1'b0; start = 1'b0; rate_bytes = '0; mode = 2'd0;
    in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_block_zero", out_block == '0, 1);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // SHA3-256, empty message
    msg_q.delete();
    run_msg(136, 2'd0, 8'h06, 0, 0);
    tmp = rx_blk[0];
    check("empty_b0", tmp[7:0], 8'h06);
    check("empty_b135", tmp[135*8 +: 8], 8'h80);

    // SHAKE128, "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(168, 2'd1, 8'h1F, 3, 0);
    tmp = rx_blk[0];
    check("abc_b3", tmp[3*8 +: 8], 8'h1F);
    check("abc_b167", tmp[167*8 +: 8], 8'h80);

    // SHA3, 135 bytes: suffix and final bit share byte 135
    msg_q.delete();
    for (int i = 0; i < 135; i++) msg_q.push_back(8'hAA);
    run_msg(136, 2'd0, 8'h06, 135, 0);
    tmp = rx_blk[0];
    check("r135_b135", tmp[135*8 +: 8], 8'h86);

    // SHA3, exactly one block of data -> extra padding block
    msg_q.delete();
    for (int i = 0; i < 136; i++) msg_q.push_back(8'(i ^ 8'h5A));
    run_msg(136, 2'd0, 8'h06, 136, 0);
    tmp = rx_blk[1];
    check("full_b2_b0", tmp[7:0], 8'h06);
    check("full_b2_b135", tmp[135*8 +: 8], 8'h80);

    // SHAKE256 300 bytes with backpressure
    msg_q.delete();
    for (int i = 0; i < 300; i++) msg_q.push_back(8'(i * 7 + 3));
    run_msg(136, 2'd1, 8'h1F, 300, 5);
    tmp = rx_blk[2];
    check("bp_b28", tmp[28*8 +: 8], 8'h1F);
    check("bp_b135", tmp[135*8 +: 8], 8'h80);

    // cSHAKE and raw Keccak suffixes at other rates
    msg_q.delete();
    for (int i = 0; i < 10; i++) msg_q.push_back(8'(8'hC0 + i));
    run_msg(72, 2'd2, 8'h04, 10, 0);
    run_msg(104, 2'd3, 8'h01, 5, 0);

    bad_start(0);
    bad_start(12);
    bad_start(176);

    // Reset in the middle of absorbing
    start = 1'b1; rate_bytes = RATE_W'(136); mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_keep = 1'b1; in_data = 8'h33; in_last = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_block_zero", out_block == '0, 1);
    check("arst_out_last", out_last, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    in_valid = 1'b0; in_keep = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    msg_q = '{8'h11, 8'h22, 8'h33};
    run_msg(136, 2'd0, 8'h06, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pad10_1_stream.md
# pad10_1_stream

Streaming, parametrised pad10*1 padder for the KMAC/Keccak datapath. It accepts message bytes over a valid/ready stream and packs them into rate-sized blocks. It appends the mode-dependent domain-separation suffix and the final 0x80 bit, then hands complete blocks to the permutation/absorb stage over a second valid/ready stream. The rate is selected at runtime and multi-block messages are supported, which includes the extra all-padding block when a message ends exactly on a block boundary.

## Interface
- RATE_MAX, 168: largest rate in bytes (SHAKE128); sets out_block width.
- RATE_W, $clog2(RATE_MAX+1): width of rate_bytes and the internal byte index.
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  begin a message. Sampled only in IDLE.
- rate_bytes  in  RATE_W  rate in bytes, sampled on start.
- mode  in  2  suffix select, sampled on start: 0 SHA3 (0x06), 1 SHAKE (0x1F), 2 cSHAKE (0x04), 3 raw Keccak (0x01).
- in_valid  in  1  input byte beat valid.
- in_ready  out  1  high only in ABSORB.
- in_data  in  8  message byte.
- in_keep  in  1  beat carries a byte. Ignored unless in_last=1; keep=0 with last=1 means "end, no byte".
- in_last  in  1  final beat of the message.
- out_valid  out  1  out_block holds a complete block.
- out_ready  in  1  consumer accepts the block.
- out_block  out  8*RATE_MAX  byte i is at bits [8i+7:8i]; bytes >= rate are zero.
- out_last  out  1  current block is the final block of the message.
- done  out  1  one-cycle pulse after the final block handshake.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, ABSORB, PAD, EMIT.
- **IDLE**
  - start with a legal rate: latch rate and mode, clear the buffer, idx=0, pad_pend=0, go to ABSORB.
  - A legal rate is a multiple of 8, at least 8, and at most RATE_MAX.
  - start with an illegal rate: pulse err and stay in IDLE.
- **ABSORB** (handshake is in_valid & in_ready):
  - A data beat (in_keep=1 or in_last=0) writes in_data at idx and increments idx.
  - Beat with in_last:
    - If the block is not yet full, go to PAD.
    - If the beat writes byte rate-1, set pad_pend and go to EMIT with out_last=0.
  - Beat without in_last that writes byte rate-1: go to EMIT with out_last=0.
  - in_last with in_keep=0 writes nothing and goes to PAD.
- **PAD** (single cycle):
  - buffer[idx] |= suffix.
  - buffer[rate-1] |= 0x80. When idx = rate-1 the result is one byte, e.g. SHA3 gives 0x86.
  - Set out_last=1 and go to EMIT.
- **EMIT**
  - out_valid=1; out_block and out_last are held stable until out_ready.
  - On handshake with out_last=1: go to IDLE and pulse done the next cycle.
  - On handshake with out_last=0: clear the buffer, idx=0, then go to PAD if pad_pend (clearing pad_pend) or to ABSORB otherwise.
- start outside IDLE is ignored. In_valid outside ABSORB is not consumed.
- Reset, including mid-message: state IDLE, buffer 0, idx 0, pad_pend 0.

## Timing
- Reset values of all outputs are 0: in_ready, out_valid, out_block, out_last, done, err.
- start at cycle t: in_ready=1 from t+1.
- Byte completing a non-final block at t: out_valid at t+1.
- in_last beat at t (block not full): PAD at t+1, out_valid at t+2.
- Final-block handshake at t: done at t+1, IDLE at t+1, next start accepted at t+1.
- Non-final handshake at t: in_ready=1 at t+1, or PAD at t+1 when pad_pend is set.
- err at t+1 after an illegal start at t.
- Throughput: 1 byte/cycle, plus one bubble cycle per emitted block.

## Structure
- Shared package kmac_pkg holds:
  - the mode enum and the suffix constants 0x06/0x1F/0x04/0x01;
  - PAD_FINAL=8'h80;
  - the state enum;
  - a function mode_to_suffix().
- Single module; no sub-module is needed. Byte writes use an idx-decoded byte enable.

## Test plan
- SHA3-256, rate 136, empty message (in_last, in_keep=0) -> one block, byte0=0x06, byte135=0x80, all other bytes 0, out_last=1, done one cycle after the handshake.
- SHAKE128, rate 168, bytes 61 62 63 -> byte0..2 = 61 62 63, byte3=0x1F, byte167=0x80, single block.
- SHA3, rate 136, 135 bytes 0xAA -> single block with byte135=0x86.
- SHA3, rate 136, 136 bytes -> block 1 is all data with out_last=0. Block 2 has byte0=0x06, byte135=0x80, out_last=1.
- Backpressure: 300-byte SHAKE256 message (rate 136) with out_ready held low 5 cycles at each EMIT.
  - in_ready is 0 and out_block is stable throughout each stall.
  - Three blocks are produced; the last has byte28=0x1F and byte135=0x80.
- start with rate_bytes 0, 12 or 176 -> err pulse, stays in IDLE.
- rst_n asserted mid-ABSORB -> all outputs 0 immediately; a new message then pads correctly.
